wordle_ps2_kbd: RTL and testbench



---
 rtl/wordle_pkg.sv | 67 ++++++
 rtl/wordle_ps2_kbd_if.sv | 22 ++
 rtl/wordle_ps2_frame.sv | 144 ++++++++++++++
 rtl/wordle_ps2_kbd.sv | 126 ++++++++++++
 tb/tb_wordle_ps2_kbd.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Scan-code constants, state encodings and the set-2 letter map for the PS/2 keyboard path.
// Pure declarations; no latency, no backpressure.
package wordle_pkg;

    localparam int LETTER_W = 5;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_DATA,
        FS_PARITY,
        FS_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DS_NORM,
        DS_BRK,
        DS_EXT,
        DS_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic                hit;
        logic [LETTER_W-1:0] idx;
    } letter_hit_t;

    function automatic letter_hit_t scan_to_letter(input logic [7:0] code);
        letter_hit_t r;
        r.hit = 1'b1;
        r.idx = '0;
        case (code)
            8'h1C: r.idx = 5'd0;
            8'h32: r.idx = 5'd1;
            8'h21: r.idx = 5'd2;
            8'h23: r.idx = 5'd3;
            8'h24: r.idx = 5'd4;
            8'h2B: r.idx = 5'd5;
            8'h34: r.idx = 5'd6;
            8'h33: r.idx = 5'd7;
            8'h43: r.idx = 5'd8;
            8'h3B: r.idx = 5'd9;
            8'h42: r.idx = 5'd10;
            8'h4B: r.idx = 5'd11;
            8'h3A: r.idx = 5'd12;
            8'h31: r.idx = 5'd13;
            8'h44: r.idx = 5'd14;
            8'h4D: r.idx = 5'd15;
            8'h15: r.idx = 5'd16;
            8'h2D: r.idx = 5'd17;
            8'h1B: r.idx = 5'd18;
            8'h2C: r.idx = 5'd19;
            8'h3C: r.idx = 5'd20;
            8'h2A: r.idx = 5'd21;
            8'h1D: r.idx = 5'd22;
            8'h22: r.idx = 5'd23;
            8'h35: r.idx = 5'd24;
            8'h1A: r.idx = 5'd25;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wordle_ps2_kbd_if.sv
// Byte and key-event outputs of the PS/2 keyboard front end.
// All strobes are single-cycle pulses; the consumer cannot stall them.
interface wordle_ps2_kbd_if;
    import wordle_pkg::*;

    logic                byte_valid;
    logic [7:0]          scan_byte;
    logic                key_valid;
    logic [LETTER_W-1:0] key_letter;
    logic                key_enter;
    logic                key_bksp;
    logic                frame_err;

    modport master (
        output byte_valid, scan_byte, key_valid, key_letter, key_enter, key_bksp, frame_err
    );

    modport slave (
        input byte_valid, scan_byte, key_valid, key_letter, key_enter, key_bksp, frame_err
    );

endinterface

// File: rtl/wordle_ps2_frame.sv
// PS/2 device-to-host receiver: pin sync, glitch filter, 11-bit frame check, timeout.
// byte_valid/frame_err 1 cycle after the accepting clock fall; no backpressure (pulses).
module wordle_ps2_frame
    import wordle_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] scan_byte,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];

    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    scan_byte_q, scan_byte_d;
    logic          frame_err_q, frame_err_d;

    logic          fall;
    logic          dat;

    // A level is adopted only after FILTER_LEN consecutive samples disagree with the current one.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign fall = filt_q[0] & ~filt_d[0];
    assign dat  = filt_q[1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        scan_byte_d  = scan_byte_q;
        frame_err_d  = 1'b0;
        tmo_d        = (fall || state_q == FS_IDLE) ? '0 : tmo_q + TW'(1);

        if (fall) begin
            case (state_q)
                FS_IDLE: begin
                    if (!dat) begin
                        state_d   = FS_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                FS_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = FS_PARITY;
                    end
                end
                FS_PARITY: begin
                    par_d   = dat;
                    state_d = FS_STOP;
                end
                FS_STOP: begin
                    if (dat && (^{shift_q, par_q})) begin
                        byte_valid_d = 1'b1;
                        scan_byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = FS_IDLE;
                end
                default: state_d = FS_IDLE;
            endcase
        end else if (state_q != FS_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            frame_err_d = 1'b1;
            state_d     = FS_IDLE;
            shift_d     = '0;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            filt_q       <= '1;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
            end
            state_q      <= FS_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            scan_byte_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= {ps2_data, ps2_clk};
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            scan_byte_q  <= scan_byte_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign scan_byte  = scan_byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/wordle_ps2_kbd.sv
// PS/2 keyboard to Wordle key events (A-Z, Enter, Backspace) with break/extend/typematic handling.
// key_valid 1 cycle after byte_valid (2 after the accepting fall); no backpressure (pulses).
module wordle_ps2_kbd
    import wordle_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    wordle_ps2_kbd_if.master  kbd
);

    logic       byte_valid_w;
    logic [7:0] scan_byte_w;
    logic       frame_err_w;

    wordle_ps2_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .Clk        (Clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid_w),
        .scan_byte  (scan_byte_w),
        .frame_err  (frame_err_w)
    );

    dec_state_t          dec_q, dec_d;
    logic [7:0]          held_q, held_d;
    logic                key_valid_q, key_valid_d;
    logic [LETTER_W-1:0] key_letter_q, key_letter_d;
    logic                key_enter_q, key_enter_d;
    logic                key_bksp_q, key_bksp_d;
    logic                mk;
    logic [7:0]          mk_code;
    letter_hit_t         lh;

    always_comb begin
        dec_d        = dec_q;
        held_d       = held_q;
        key_valid_d  = 1'b0;
        key_letter_d = '0;
        key_enter_d  = 1'b0;
        key_bksp_d   = 1'b0;
        mk           = 1'b0;
        mk_code      = scan_byte_w;

        if (byte_valid_w) begin
            case (dec_q)
                DS_NORM: begin
                    if (scan_byte_w == SC_BREAK) begin
                        dec_d = DS_BRK;
                    end else if (scan_byte_w == SC_EXT) begin
                        dec_d = DS_EXT;
                    end else begin
                        mk = 1'b1;
                    end
                end
                DS_EXT: begin
                    if (scan_byte_w == SC_BREAK) begin
                        dec_d = DS_EXT_BRK;
                    end else begin
                        mk    = (scan_byte_w == SC_ENTER);
                        dec_d = DS_NORM;
                    end
                end
                // Extended release of 5A shares the plain Enter code, so both break states act alike.
                DS_BRK, DS_EXT_BRK: begin
                    if (scan_byte_w == held_q) begin
                        held_d = '0;
                    end
                    dec_d = DS_NORM;
                end
                default: dec_d = DS_NORM;
            endcase
        end

        lh = scan_to_letter(mk_code);

        if (mk && mk_code != held_q) begin
            held_d = mk_code;
            if (lh.hit) begin
                key_valid_d  = 1'b1;
                key_letter_d = lh.idx;
            end else if (mk_code == SC_ENTER) begin
                key_valid_d = 1'b1;
                key_enter_d = 1'b1;
            end else if (mk_code == SC_BKSP) begin
                key_valid_d = 1'b1;
                key_bksp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            dec_q        <= DS_NORM;
            held_q       <= '0;
            key_valid_q  <= 1'b0;
            key_letter_q <= '0;
            key_enter_q  <= 1'b0;
            key_bksp_q   <= 1'b0;
        end else begin
            dec_q        <= dec_d;
            held_q       <= held_d;
            key_valid_q  <= key_valid_d;
            key_letter_q <= key_letter_d;
            key_enter_q  <= key_enter_d;
            key_bksp_q   <= key_bksp_d;
        end
    end

    assign kbd.byte_valid = byte_valid_w;
    assign kbd.scan_byte  = scan_byte_w;
    assign kbd.frame_err  = frame_err_w;
    assign kbd.key_valid  = key_valid_q;
    assign kbd.key_letter = key_letter_q;
    assign kbd.key_enter  = key_enter_q;
    assign kbd.key_bksp   = key_bksp_q;

endmodule

// File: tb/tb_wordle_ps2_kbd.sv
// Directed bench for wordle_ps2_kbd: PS/2 frames driven on the pins, event pulses counted at negedge.
// PS/2 bit rate and timeout are scaled down so the whole run stays short.
module tb_wordle_ps2_kbd;
    import wordle_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 50;
    localparam int GAP  = 300;

    logic Clk      = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    wordle_ps2_kbd_if kbd_if ();

    wordle_ps2_kbd #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .Clk      (Clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kbd      (kbd_if)
    );

    always #5 Clk = ~Clk;

    int         n_vec = 0, n_bad = 0;
    int         cyc = 0, n_byte = 0, n_key = 0, n_err = 0;
    int         byte_cyc = 0, key_cyc = 0;
    int         b0 = 0, k0 = 0, e0 = 0;
    logic [7:0] last_scan = '0;
    logic [4:0] last_letter = '0;
    logic       last_enter = 1'b0, last_bksp = 1'b0;

    always @(negedge Clk) begin
        cyc++;
        if (kbd_if.byte_valid) begin
            n_byte++;
            last_scan = kbd_if.scan_byte;
            byte_cyc  = cyc;
        end
        if (kbd_if.key_valid) begin
            n_key++;
            last_letter = kbd_if.key_letter;
            last_enter  = kbd_if.key_enter;
            last_bksp   = kbd_if.key_bksp;
            key_cyc     = cyc;
        end
        if (kbd_if.frame_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b0 = n_byte;
        k0 = n_key;
        e0 = n_err;
    endtask

    // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                repeat (HALF / 2) @(negedge Clk);
                ps2_clk = 1'b0;
                @(negedge Clk);
                ps2_clk = 1'b1;
                repeat (HALF - HALF / 2 - 1) @(negedge Clk);
            end else begin
                repeat (HALF) @(negedge Clk);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                repeat (HALF / 2) @(negedge Clk);
                ps2_clk = 1'b1;
                @(negedge Clk);
                ps2_clk = 1'b0;
                repeat (HALF - HALF / 2 - 1) @(negedge Clk);
            end else begin
                repeat (HALF) @(negedge Clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bits(mk_frame(b, bad_par, 1'b1), 11, glitch);
        repeat (GAP) @(negedge Clk);
    endtask

    initial begin
        repeat (5) @(negedge Clk);
        chk("rst_byte_valid", kbd_if.byte_valid, 0);
        chk("rst_scan_byte",  kbd_if.scan_byte, 0);
        chk("rst_key_valid",  kbd_if.key_valid, 0);
        chk("rst_key_letter", kbd_if.key_letter, 0);
        chk("rst_key_qual",   {kbd_if.key_enter, kbd_if.key_bksp}, 0);
        chk("rst_frame_err",  kbd_if.frame_err, 0);
        reset = 1'b0;
        repeat (20) @(negedge Clk);
        chk("idle_quiet", n_byte + n_key + n_err, 0);

        // letter A, then check the byte-to-key spacing
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("a_bytes",  n_byte - b0, 1);
        chk("a_scan",   last_scan, 8'h1C);
        chk("a_keys",   n_key - k0, 1);
        chk("a_letter", last_letter, 0);
        chk("a_qual",   {last_enter, last_bksp}, 0);
        chk("a_lat",    key_cyc - byte_cyc, 1);

        // R held with typematic repeats, released, pressed again
        snap();
        send_frame(8'h2D, 1'b0, 1'b0);
        chk("r_first",  n_key - k0, 1);
        chk("r_letter", last_letter, 17);
        send_frame(8'h2D, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        chk("r_repeat", n_key - k0, 1);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        chk("r_release_no_key", n_key - k0, 1);
        send_frame(8'h2D, 1'b0, 1'b0);
        chk("r_second",  n_key - k0, 2);
        chk("r_letter2", last_letter, 17);
        chk("r_bytes",   n_byte - b0, 6);
        chk("r_errs",    n_err - e0, 0);

        // extended Enter press/release, Backspace press/release
        snap();
        send_frame(SC_EXT, 1'b0, 1'b0);
        send_frame(SC_ENTER, 1'b0, 1'b0);
        chk("ent_keys",   n_key - k0, 1);
        chk("ent_flags",  {last_enter, last_bksp}, 2'b10);
        chk("ent_letter", last_letter, 0);
        send_frame(SC_EXT, 1'b0, 1'b0);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(SC_ENTER, 1'b0, 1'b0);
        chk("ent_release", n_key - k0, 1);
        send_frame(SC_BKSP, 1'b0, 1'b0);
        chk("bks_keys",   n_key - k0, 2);
        chk("bks_flags",  {last_enter, last_bksp}, 2'b01);
        chk("bks_letter", last_letter, 0);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(SC_BKSP, 1'b0, 1'b0);
        chk("bks_release", n_key - k0, 2);

        // wrong parity, then the same byte good
        snap();
        send_frame(8'h24, 1'b1, 1'b0);
        chk("par_err",   n_err - e0, 1);
        chk("par_bytes", n_byte - b0, 0);
        chk("par_keys",  n_key - k0, 0);
        send_frame(8'h24, 1'b0, 1'b0);
        chk("e_keys",   n_key - k0, 1);
        chk("e_letter", last_letter, 4);

        // stop bit low
        snap();
        send_bits(mk_frame(8'h43, 1'b0, 1'b0), 11, 1'b0);
        repeat (GAP) @(negedge Clk);
        chk("stop_err",   n_err - e0, 1);
        chk("stop_bytes", n_byte - b0, 0);

        // start bit high
        snap();
        send_bits(11'h001, 1, 1'b0);
        repeat (GAP) @(negedge Clk);
        chk("start_err",   n_err - e0, 1);
        chk("start_bytes", n_byte - b0, 0);

        // truncated frame: quiet before the timeout, error after it
        snap();
        send_bits(mk_frame(8'h1A, 1'b0, 1'b1), 5, 1'b0);
        repeat (TMO * 9 / 10) @(negedge Clk);
        chk("tmo_early", n_err - e0, 0);
        repeat (TMO * 3 / 10) @(negedge Clk);
        chk("tmo_err",   n_err - e0, 1);
        chk("tmo_bytes", n_byte - b0, 0);
        send_frame(8'h1A, 1'b0, 1'b0);
        chk("z_keys",   n_key - k0, 1);
        chk("z_letter", last_letter, 25);

        // single-cycle clock glitches in both phases of every bit
        snap();
        send_frame(8'h15, 1'b0, 1'b1);
        chk("gl_bytes",  n_byte - b0, 1);
        chk("gl_scan",   last_scan, 8'h15);
        chk("gl_letter", last_letter, 16);
        chk("gl_errs",   n_err - e0, 0);

        // reset mid-frame
        snap();
        send_bits(mk_frame(8'h4D, 1'b0, 1'b1), 5, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rstm_fsm", 32'(u_dut.u_frame.state_q), 32'(FS_IDLE));
        repeat (GAP) @(negedge Clk);
        chk("rstm_pulses", (n_byte - b0) + (n_key - k0) + (n_err - e0), 0);
        send_frame(8'h4D, 1'b0, 1'b0);
        chk("p_keys",   n_key - k0, 1);
        chk("p_letter", last_letter, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
